sys_feed_seq: RTL and testbench
===============================

Name: sys_feed_seq

Overview:
- Phase sequencer and data feeder on the initiator side of the systolic array's w_ps load protocol.
- On each start it streams W_BEATS weight words with w_ps=1, inserts one gap cycle, then streams A_BEATS activation words with w_ps=0.
- It then waits DRAIN_CYCLES for partial sums to flush and pulses done.
- Sits between the on-chip operand buffer (valid/ready source) and the array's row inputs and control FSM.

Parameters:
- DW, 8: data word width.
- W_BEATS, 4: weight words per tile, at least 1.
- A_BEATS, 16: activation words per tile, at least 1.
- DRAIN_CYCLES, 4: idle cycles after the last activation, covering array depth; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run one tile; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at tile completion.
- in_data  in  DW  operand word from the buffer.
- in_valid  in  1  buffer word valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- arr_data  out  DW  word driven to the array.
- arr_valid  out  1  arr_data is valid this cycle.
- w_ps  out  1  1 = weight-load phase, 0 = partial-sum/compute phase.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, all counters 0, busy=0, done=0, in_ready=0, arr_valid=0, arr_data=0, w_ps=0.
- Reset mid-operation: return to IDLE on the next edge. Partially sent words are abandoned, no done pulse is issued, and the next start begins a fresh tile.
- States and transitions:
  - IDLE: start=1 -> WLOAD.
  - WLOAD: in_ready=1. Each accept (in_valid && in_ready) increments wcnt. The accept with wcnt==W_BEATS-1 moves to GAP.
  - GAP: exactly one cycle. in_ready=0, arr_valid=0, w_ps=0. Then -> COMPUTE.
  - COMPUTE: in_ready=1. Each accept increments acnt. The accept with acnt==A_BEATS-1 moves to DRAIN.
  - DRAIN: in_ready=0. dcnt counts DRAIN_CYCLES cycles, then -> DONE.
  - DONE: one cycle, done=1, then -> IDLE.
- in_ready is decoded combinationally from state only and never depends on in_valid.
- Output registers:
  - arr_data and arr_valid are registered, one cycle after the accept.
  - arr_valid=0 on any non-accept cycle. arr_data holds its last value when arr_valid=0.
- w_ps rules:
  - w_ps is registered and equals 1 on the cycle after each WLOAD accept.
  - It stays 1 through WLOAD stalls (in_valid=0) so the array's controller does not leave its load state.
  - It is 0 from the GAP-registered cycle onward and 0 in IDLE.
  - The array therefore sees one contiguous w_ps=1 window carrying exactly W_BEATS valid beats, followed by at least one w_ps=0, arr_valid=0 cycle.
- Counters:
  - Widths are $clog2(max(param,2)) bits.
  - Counters clear on entry to WLOAD and never wrap within a tile.
- Start handling:
  - start while busy=1 is ignored and not queued.
  - start in the DONE cycle is ignored.
  - start on the first IDLE cycle after DONE is accepted, so back-to-back tiles are spaced by one IDLE cycle.
- Backpressure: there is no backpressure from the array. The array must consume arr_data every arr_valid cycle.

Optional Feature:
- Macro: SYS_FEED_SEQ_WREUSE_EN.
- With the macro defined:
  - An extra input port reuse_w (1 bit) is added and sampled together with start in IDLE.
  - start=1 with reuse_w=1 skips WLOAD and goes IDLE -> GAP -> COMPUTE, keeping weights already resident in the array. w_ps stays 0 for the whole tile.
  - start=1 with reuse_w=0 behaves exactly as the base design.
- Without the macro: the port is absent and every tile loads weights.

Test Plan:
- Basic tile: defaults, start=1, in_valid held 1 with data 1..20. Expect arr_valid with w_ps=1 for words 1-4 on consecutive cycles, one gap cycle, words 5-20 with w_ps=0, 4 drain cycles, done=1 for one cycle, busy=0 the cycle after done.
- Weight stall: in_valid=0 for 3 cycles after the 2nd weight word. Expect w_ps to stay 1 through the stall with arr_valid=0, exactly 4 weight beats in total, and the GAP cycle only after the 4th.
- Activation stall: random in_valid on 50% of cycles during COMPUTE. Expect exactly 16 arr_valid beats with w_ps=0 and in-order data; done only after the last beat plus 4 drain cycles.
- Start filtering: pulse start during COMPUTE and during DONE. Expect no effect, and exactly one tile and one done pulse. A start on the following IDLE cycle begins a new tile with w_ps=1 beats.
- Reset mid-WLOAD: assert rst after 2 weight beats. The next cycle shows IDLE outputs all 0 with no done. A fresh start gives a full 4-beat weight load.
- Macro SYS_FEED_SEQ_WREUSE_EN: start with reuse_w=1. Expect no w_ps=1 cycles, the GAP cycle, 16 activation beats, then done.

Source files
------------

// File: rtl/sys_feed_seq_if.sv
// sys_feed_seq_if: stream bundle between the operand buffer, the feed
// sequencer and the systolic array row inputs.
//
//   in_data   operand word from the buffer
//   in_valid  buffer word valid
//   in_ready  sequencer accepts a word this cycle
//   arr_data  word driven to the array
//   arr_valid arr_data is valid this cycle
//   w_ps      1 = weight-load phase, 0 = partial-sum/compute phase
//
// master: the sequencer side; slave: the buffer/array side.
interface sys_feed_seq_if #(
    parameter int DW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] arr_data;
    logic          arr_valid;
    logic          w_ps;

    modport master (
        input  in_data, in_valid,
        output in_ready, arr_data, arr_valid, w_ps
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, arr_data, arr_valid, w_ps
    );
endinterface

// File: rtl/sys_feed_seq.sv
// sys_feed_seq: phase sequencer and data feeder for the systolic array's
// w_ps load protocol. Each start streams W_BEATS weight words (w_ps=1),
// one gap cycle, A_BEATS activation words (w_ps=0), waits DRAIN_CYCLES
// for partial sums to flush, then pulses done.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   one-cycle tile request, sampled only in IDLE
//   reuse_w (only with SYS_FEED_SEQ_WREUSE_EN) skip the weight load
//   busy    high in every state except IDLE
//   done    one-cycle pulse at tile completion
//   bus     sys_feed_seq_if master: in_* from the buffer, arr_*/w_ps
//           to the array (registered, one cycle after the accept)
//
// Optional feature macro: SYS_FEED_SEQ_WREUSE_EN adds reuse_w; start with
// reuse_w=1 goes IDLE -> GAP -> COMPUTE and keeps resident weights.
module sys_feed_seq #(
    parameter int DW           = 8,
    parameter int W_BEATS      = 4,
    parameter int A_BEATS      = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef SYS_FEED_SEQ_WREUSE_EN
    input  logic reuse_w,
`endif
    output logic busy,
    output logic done,
    sys_feed_seq_if.master bus
);

    localparam int WCW = $clog2((W_BEATS      < 2) ? 2 : W_BEATS);
    localparam int ACW = $clog2((A_BEATS      < 2) ? 2 : A_BEATS);
    localparam int DCW = $clog2((DRAIN_CYCLES < 2) ? 2 : DRAIN_CYCLES);

    localparam logic [WCW-1:0] W_LAST = WCW'(W_BEATS - 1);
    localparam logic [ACW-1:0] A_LAST = ACW'(A_BEATS - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_GAP,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q,     state_d;
    logic [WCW-1:0]  wcnt_q,      wcnt_d;
    logic [ACW-1:0]  acnt_q,      acnt_d;
    logic [DCW-1:0]  dcnt_q,      dcnt_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;
    logic [DW-1:0]   arr_data_q,  arr_data_d;
    logic            arr_valid_q, arr_valid_d;
    logic            w_ps_q,      w_ps_d;
    logic            load_w;
    logic            accept;

    // Ready depends on state only, never on in_valid.
    assign bus.in_ready = (state_q == S_WLOAD) || (state_q == S_COMPUTE);
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef SYS_FEED_SEQ_WREUSE_EN
    assign load_w = !reuse_w;
`else
    assign load_w = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        acnt_d      = acnt_q;
        dcnt_d      = dcnt_q;
        done_d      = 1'b0;
        arr_data_d  = arr_data_q;
        arr_valid_d = 1'b0;
        w_ps_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wcnt_d  = '0;
                    acnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = load_w ? S_WLOAD : S_GAP;
                end
            end
            S_WLOAD: begin
                // w_ps latches high on the first accept and holds through
                // stalls so the array stays in its load state.
                w_ps_d = w_ps_q || accept;
                if (accept) begin
                    arr_data_d  = bus.in_data;
                    arr_valid_d = 1'b1;
                    if (wcnt_q == W_LAST) begin
                        state_d = S_GAP;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (accept) begin
                    arr_data_d  = bus.in_data;
                    arr_valid_d = 1'b1;
                    if (acnt_q == A_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == D_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            acnt_q      <= '0;
            dcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arr_data_q  <= '0;
            arr_valid_q <= 1'b0;
            w_ps_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            acnt_q      <= acnt_d;
            dcnt_q      <= dcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            arr_data_q  <= arr_data_d;
            arr_valid_q <= arr_valid_d;
            w_ps_q      <= w_ps_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.arr_data  = arr_data_q;
    assign bus.arr_valid = arr_valid_q;
    assign bus.w_ps      = w_ps_q;

endmodule

// File: tb/tb_sys_feed_seq.sv
// Bench for sys_feed_seq: a driver pushes expected beats into a scoreboard
// queue as words are handed over; a monitor pops and compares every
// arr_valid beat and logs per-cycle outputs for tile timing analysis.
module tb_sys_feed_seq;

    localparam int DW = 8;
    localparam int WB = 4;
    localparam int AB = 16;
    localparam int DC = 4;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
`ifdef SYS_FEED_SEQ_WREUSE_EN
    logic reuse_w;
`endif

    sys_feed_seq_if #(.DW(DW)) bus ();

    sys_feed_seq #(
        .DW(DW),
        .W_BEATS(WB),
        .A_BEATS(AB),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef SYS_FEED_SEQ_WREUSE_EN
        .reuse_w(reuse_w),
`endif
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW:0] sbq[$];
    bit av_l[LOGN];
    bit wp_l[LOGN];
    bit dn_l[LOGN];
    bit by_l[LOGN];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: logs outputs at every negedge and checks each beat.
    always @(negedge clk) begin
        logic [DW:0] exp_b;
        if (cyc < LOGN) begin
            av_l[cyc] = bus.arr_valid;
            wp_l[cyc] = bus.w_ps;
            dn_l[cyc] = done;
            by_l[cyc] = busy;
        end
        if (bus.arr_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected w_ps=%0b data=%0d with empty queue",
                         bus.w_ps, bus.arr_data);
            end else begin
                exp_b = sbq.pop_front();
                if ({bus.w_ps, bus.arr_data} !== exp_b) begin
                    errors++;
                    $display("FAIL beat: got w_ps=%0b data=%0d expected w_ps=%0b data=%0d",
                             bus.w_ps, bus.arr_data, exp_b[DW], exp_b[DW-1:0]);
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " busy"},      int'(busy),          0);
        chk({nm, " done"},      int'(done),          0);
        chk({nm, " in_ready"},  int'(bus.in_ready),  0);
        chk({nm, " arr_valid"}, int'(bus.arr_valid), 0);
        chk({nm, " arr_data"},  int'(bus.arr_data),  0);
        chk({nm, " w_ps"},      int'(bus.w_ps),      0);
    endtask

    task automatic analyze(input string nm, input int c0, input int c1, input int nw,
                           input int ewc, input bit tight);
        int nwb = 0, nab = 0, nwp = 0, ndn = 0;
        int fwb = -1, lwb = -1, fab = -1, lab = -1, fwp = -1, lwp = -1, dcyc = -1;
        for (int c = c0; c <= c1; c++) begin
            if (av_l[c] && wp_l[c]) begin nwb++; lwb = c; if (fwb < 0) fwb = c; end
            if (av_l[c] && !wp_l[c]) begin nab++; lab = c; if (fab < 0) fab = c; end
            if (wp_l[c]) begin nwp++; lwp = c; if (fwp < 0) fwp = c; end
            if (dn_l[c]) begin ndn++; dcyc = c; end
        end
        chk({nm, " weight beats"}, nwb, nw);
        chk({nm, " act beats"},    nab, AB);
        chk({nm, " w_ps cycles"},  nwp, ewc);
        if (ewc > 0) begin
            chk({nm, " w_ps window"}, lwp - fwp + 1, ewc);
            chk({nm, " gap after w_ps"}, int'(av_l[lwp+1]) + int'(wp_l[lwp+1]), 0);
        end
        chk({nm, " done pulses"},     ndn, 1);
        chk({nm, " drain length"},    dcyc - lab, DC);
        chk({nm, " idle after done"}, int'(by_l[c1]), 0);
        if (tight) begin
            chk({nm, " first beat latency"}, ((nw > 0) ? fwb : fab) - c0, (nw > 0) ? 2 : 3);
            if (nw > 0) chk({nm, " gap spacing"}, fab - lwb, 2);
        end
    endtask

    // Runs one tile from the current cycle; returns at the first cycle
    // after done. A stall of stall_len cycles is inserted before word
    // stall_at; amask gates in_valid per cycle in the activation phase.
    task automatic run_tile(input string nm, input bit reuse, input int base,
                            input int stall_at, input int stall_len,
                            input logic [31:0] amask, input bit extra,
                            input bit tight, input int ewc);
        int nw, i, stalls, mb, guard, c0;
        bit v, sent;
        nw = reuse ? 0 : WB;
        c0 = cyc - 1;
        start = 1'b1;
`ifdef SYS_FEED_SEQ_WREUSE_EN
        reuse_w = reuse;
`endif
        step();
        start = 1'b0;
`ifdef SYS_FEED_SEQ_WREUSE_EN
        reuse_w = 1'b0;
`endif
        i = 0; stalls = 0; mb = 0; guard = 0; sent = 0;
        while (i < nw + AB && guard < 400) begin
            if (i == stall_at && stalls < stall_len) begin
                v = 1'b0;
                stalls++;
            end else if (i >= nw) begin
                v = amask[mb];
                mb = (mb + 1) % 32;
            end else begin
                v = 1'b1;
            end
            start = extra && !sent && (i == nw + 3);
            if (start) sent = 1'b1;
            bus.in_valid = v;
            bus.in_data  = DW'(base + i);
            if (v && bus.in_ready) begin
                sbq.push_back({(i < nw) ? 1'b1 : 1'b0, DW'(base + i)});
                i++;
            end
            step();
            start = 1'b0;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (guard >= 400) chk({nm, " feed timeout"}, i, nw + AB);
        guard = 0;
        while (!done && guard < 200) begin
            step();
            guard++;
        end
        if (!done) begin
            chk({nm, " done timeout"}, 0, 1);
        end else begin
            if (extra) start = 1'b1;
            step();
            start = 1'b0;
        end
        analyze(nm, c0, cyc - 1, nw, ewc, tight);
    endtask

    initial begin
        int c0, ndn;
        rst = 1'b1;
        start = 1'b0;
`ifdef SYS_FEED_SEQ_WREUSE_EN
        reuse_w = 1'b0;
`endif
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;
        step();

        run_tile("basic", 1'b0, 1, -1, 0, '1, 1'b0, 1'b1, 4);
        step();
        run_tile("wstall", 1'b0, 40, 2, 3, '1, 1'b0, 1'b0, 7);
        step();
        run_tile("astall", 1'b0, 80, -1, 0, 32'hB4D2_6A95, 1'b0, 1'b0, 4);
        step();
        // Starts in COMPUTE and DONE are ignored; the start in the first
        // IDLE cycle after done launches the next tile back to back.
        run_tile("filter", 1'b0, 100, -1, 0, '1, 1'b1, 1'b1, 4);
        run_tile("b2b", 1'b0, 130, -1, 0, '1, 1'b0, 1'b1, 4);
        step();

        c0 = cyc - 1;
        start = 1'b1;
        step();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(160);
        sbq.push_back({1'b1, DW'(160)});
        step();
        bus.in_data  = DW'(161);
        sbq.push_back({1'b1, DW'(161)});
        step();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check_idle("mid reset");
        ndn = 0;
        for (int c = c0; c < cyc; c++) ndn += int'(dn_l[c]);
        chk("mid reset done pulses", ndn, 0);
        chk("mid reset queue", sbq.size(), 0);
        rst = 1'b0;
        step();
        run_tile("after reset", 1'b0, 180, -1, 0, '1, 1'b0, 1'b1, 4);
        step();

`ifdef SYS_FEED_SEQ_WREUSE_EN
        run_tile("reuse", 1'b1, 210, -1, 0, '1, 1'b0, 1'b1, 0);
        step();
`endif

        repeat (3) step();
        chk("scoreboard drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
